// File: rtl/conn_event_generator.sv
// Buffers filtered aging-info pulses and emits sequenced 64-bit event words; EVTGEN_STATS_EN enables the event/drop counters.
// Latency: pulse at t -> event_valid at t+3; input has no back-pressure, so overflow drops and counts.
module conn_event_generator #(
    parameter int w_agingInfo  = 40,
    parameter int w_event      = 64,
    parameter int w_timestamp  = 8,
    parameter int w_seq        = 16,
    parameter int d_evtBuf     = 4,
    parameter int words_evtBuf = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   agingInfo_valid,
    input  logic [w_agingInfo-1:0] agingInfo,
    input  logic [w_timestamp-1:0] cur_timestamp,
    output logic                   event_valid,
    output logic [w_event-1:0]     event_data,
    input  logic                   event_ready,
    output logic                   evtBuf_full,
    output logic [31:0]            cnt_event,
    output logic [15:0]            cnt_drop
);

    localparam int W_ENT = w_timestamp + 33;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t               state_q;
    logic [W_ENT-1:0]     mem_q [words_evtBuf];
    logic [W_ENT-1:0]     rd_dat_q;
    logic [d_evtBuf-1:0]  wr_ptr_q;
    logic [d_evtBuf-1:0]  rd_ptr_q;
    logic [d_evtBuf:0]    count_q;
    logic [d_evtBuf:0]    count_d;
    logic                 full_q;
    logic                 event_valid_q;
    logic [w_event-1:0]   event_data_q;
    logic [w_seq-1:0]     seq_q;
    logic                 info_hit;
    logic                 wrreq;
    logic                 rdreq;
    logic                 unused_bits;

    // Full is the registered flag, so a same-cycle read never frees a slot for the write.
    assign info_hit = agingInfo_valid && (agingInfo[15:8] != 8'h00);
    assign wrreq    = info_hit && !full_q;
    assign rdreq    = (state_q == IDLE) && (count_q != '0);
    assign count_d  = count_q + (d_evtBuf+1)'(wrreq) - (d_evtBuf+1)'(rdreq);

    assign unused_bits = ^{agingInfo[39:33], rd_dat_q[23:16]};

    always_ff @(posedge clk) begin
        if (wrreq) begin
            mem_q[wr_ptr_q] <= {cur_timestamp, agingInfo[32:0]};
        end
        if (rdreq) begin
            rd_dat_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (wrreq) wr_ptr_q <= wr_ptr_q + d_evtBuf'(1);
            if (rdreq) rd_ptr_q <= rd_ptr_q + d_evtBuf'(1);
            count_q <= count_d;
            full_q  <= (count_d == (d_evtBuf+1)'(words_evtBuf));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            event_valid_q <= 1'b0;
            event_data_q  <= '0;
            seq_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) state_q <= LOAD;
                end
                LOAD: begin
                    event_data_q  <= {seq_q, rd_dat_q[15:8], rd_dat_q[W_ENT-1 -: w_timestamp],
                                      rd_dat_q[7:0], 15'd0, rd_dat_q[32:24]};
                    event_valid_q <= 1'b1;
                    state_q       <= SEND;
                end
                SEND: begin
                    if (event_ready) begin
                        event_valid_q <= 1'b0;
                        seq_q         <= seq_q + w_seq'(1);
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign event_valid = event_valid_q;
    assign event_data  = event_data_q;
    assign evtBuf_full = full_q;

`ifdef EVTGEN_STATS_EN
    logic [31:0] cnt_event_q;
    logic [15:0] cnt_drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_event_q <= '0;
            cnt_drop_q  <= '0;
        end else begin
            if ((state_q == SEND) && event_ready) cnt_event_q <= cnt_event_q + 32'd1;
            if (info_hit && full_q && (cnt_drop_q != 16'hFFFF)) cnt_drop_q <= cnt_drop_q + 16'd1;
        end
    end

    assign cnt_event = cnt_event_q;
    assign cnt_drop  = cnt_drop_q;
`else
    assign cnt_event = '0;
    assign cnt_drop  = '0;
`endif

endmodule

// File: tb/tb_conn_event_generator.sv
// Directed bench for conn_event_generator: vector table for single events, hand sequences for
// back-pressure, overflow, sequence wrap and mid-transfer reset.
module tb_conn_event_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        agingInfo_valid;
    logic [39:0] agingInfo;
    logic [7:0]  cur_timestamp;
    logic        event_valid;
    logic [63:0] event_data;
    logic        event_ready;
    logic        evtBuf_full;
    logic [31:0] cnt_event;
    logic [15:0] cnt_drop;

    always #5 clk = ~clk;

    conn_event_generator dut (
        .clk            (clk),
        .reset          (reset),
        .agingInfo_valid(agingInfo_valid),
        .agingInfo      (agingInfo),
        .cur_timestamp  (cur_timestamp),
        .event_valid    (event_valid),
        .event_data     (event_data),
        .event_ready    (event_ready),
        .evtBuf_full    (evtBuf_full),
        .cnt_event      (cnt_event),
        .cnt_drop       (cnt_drop)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [63:0] exp_q [$];
    int          hs_q  [$];
    logic [15:0] exp_seq = 16'h0;
    logic [63:0] last_hs_d = 64'h0;
    logic [63:0] pop_d;
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_rst = 1'b1;
    logic [63:0] prev_d = 64'h0;

    typedef struct {
        logic [8:0]  idx;
        logic [7:0]  bm;
        logic [7:0]  last;
        logic [7:0]  cur;
        logic [7:0]  rsv;
        logic        exp_v;
        logic [63:0] exp_d;
    } vec_t;

    vec_t tv [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] stat(input int v);
`ifdef EVTGEN_STATS_EN
        return 64'(v);
`else
        return 64'(v) & 64'h0;
`endif
    endfunction

    function automatic logic [63:0] fmt(input logic [15:0] s, input logic [8:0] idx,
                                        input logic [7:0] bm, input logic [7:0] last,
                                        input logic [7:0] cur);
        return {s, bm, cur, last, 15'd0, idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pulse(input logic [8:0] idx, input logic [7:0] bm, input logic [7:0] last,
                              input logic [7:0] cur, input logic [7:0] rsv, input logic acc);
        agingInfo       = {7'd0, idx, rsv, bm, last};
        cur_timestamp   = cur;
        agingInfo_valid = 1'b1;
        if (acc && bm != 8'h00) begin
            exp_q.push_back(fmt(exp_seq, idx, bm, last, cur));
            exp_seq = exp_seq + 16'd1;
        end
        tick();
        agingInfo_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_seq = 16'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || event_valid) && n < maxc) begin
            tick();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || event_valid) begin
            n_bad++;
            $display("FAIL %s: timeout with %0d events outstanding, want 0", nm, exp_q.size());
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake scoreboard and hold-stability checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_v && !prev_hs && !prev_rst) begin
            chk("hold_valid", 64'(event_valid), 64'd1);
            chk("hold_data", event_data, prev_d);
        end
        if (event_valid && event_ready) begin
            hs_q.push_back(cyc);
            last_hs_d = event_data;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got %h, want none", event_data);
            end else begin
                pop_d = exp_q.pop_front();
                chk("event_data", event_data, pop_d);
            end
        end
        prev_v   = event_valid;
        prev_hs  = event_valid && event_ready;
        prev_rst = reset;
        prev_d   = event_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        int seen_v;

        tv[0] = '{9'h005, 8'h08, 8'h20, 8'h2A, 8'h00, 1'b1, 64'h0000_082A_2000_0005};
        tv[1] = '{9'h1FF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 64'h0001_FF00_FF00_01FF};
        tv[2] = '{9'h100, 8'h00, 8'h11, 8'h22, 8'h00, 1'b0, 64'h0};
        tv[3] = '{9'h0AA, 8'h81, 8'h7E, 8'hC3, 8'h5A, 1'b1, 64'h0002_81C3_7E00_00AA};
        tv[4] = '{9'h155, 8'h01, 8'h00, 8'h01, 8'hFF, 1'b1, 64'h0003_0101_0000_0155};

        reset           = 1'b1;
        agingInfo_valid = 1'b0;
        agingInfo       = '0;
        cur_timestamp   = '0;
        event_ready     = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_valid", 64'(event_valid), 64'd0);
        chk("rst_data", event_data, 64'h0);
        chk("rst_full", 64'(evtBuf_full), 64'd0);
        chk("rst_cnt_event", 64'(cnt_event), 64'd0);
        chk("rst_cnt_drop", 64'(cnt_drop), 64'd0);
        repeat (6) tick();

        // Table: one pulse at t, valid expected exactly at t+3 for one cycle.
        acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            send_pulse(tv[i].idx, tv[i].bm, tv[i].last, tv[i].cur, tv[i].rsv, 1'b1);
            tick();
            chk("lat_t2_valid", 64'(event_valid), 64'd0);
            tick();
            chk("lat_t3_valid", 64'(event_valid), 64'(tv[i].exp_v));
            if (tv[i].exp_v) chk("vec_data", event_data, tv[i].exp_d);
            tick();
            chk("after_hs_valid", 64'(event_valid), 64'd0);
            acc_n += int'(tv[i].exp_v);
            chk("vec_cnt_event", 64'(cnt_event), stat(acc_n));
            chk("vec_cnt_drop", 64'(cnt_drop), stat(0));
        end

        // Back-pressure: three queued events, ready low for 20 cycles.
        do_reset();
        event_ready = 1'b0;
        send_pulse(9'h011, 8'h02, 8'h10, 8'h50, 8'h00, 1'b1);
        send_pulse(9'h022, 8'h04, 8'h11, 8'h51, 8'h00, 1'b1);
        send_pulse(9'h033, 8'h10, 8'h12, 8'h52, 8'h00, 1'b1);
        repeat (20) tick();
        chk("bp_valid", 64'(event_valid), 64'd1);
        chk("bp_data", event_data, 64'h0000_0250_1000_0011);
        hs_q.delete();
        event_ready = 1'b1;
        wait_drain(40, "bp_drain");
        chk("bp_hs_count", 64'(hs_q.size()), 64'd3);
        if (hs_q.size() == 3) begin
            chk("bp_spacing1", 64'(hs_q[1] - hs_q[0]), 64'd3);
            chk("bp_spacing2", 64'(hs_q[2] - hs_q[1]), 64'd3);
        end
        chk("bp_cnt_event", 64'(cnt_event), stat(3));

        // Overflow: 20 back-to-back pulses, 1 in SEND + 16 buffered + 3 dropped.
        do_reset();
        event_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send_pulse(9'(i + 9'h40), 8'(1 << (i % 8)), 8'(i * 3), 8'(8'h40 + i), 8'h00, i < 17);
        end
        chk("ovf_full", 64'(evtBuf_full), 64'd1);
        chk("ovf_cnt_drop", 64'(cnt_drop), stat(3));
        chk("ovf_cnt_event", 64'(cnt_event), stat(0));
        chk("ovf_valid", 64'(event_valid), 64'd1);
        hs_q.delete();
        event_ready = 1'b1;
        wait_drain(150, "ovf_drain");
        chk("ovf_hs_count", 64'(hs_q.size()), 64'd17);
        for (int k = 1; k < hs_q.size(); k++) begin
            chk("ovf_spacing", 64'(hs_q[k] - hs_q[k-1]), 64'd3);
        end
        chk("ovf_full_after", 64'(evtBuf_full), 64'd0);
        chk("ovf_cnt_event_after", 64'(cnt_event), stat(17));
        chk("ovf_cnt_drop_after", 64'(cnt_drop), stat(3));

        // Filter and sequence wrap.
        do_reset();
        event_ready = 1'b1;
        tick();
        force dut.seq_q = 16'hFFFF;
        #2;
        release dut.seq_q;
        exp_seq = 16'hFFFF;
        send_pulse(9'h0F0, 8'h00, 8'h01, 8'h02, 8'h00, 1'b1);
        repeat (5) tick();
        chk("filter_valid", 64'(event_valid), 64'd0);
        chk("filter_cnt_event", 64'(cnt_event), stat(0));
        chk("filter_full", 64'(evtBuf_full), 64'd0);
        send_pulse(9'h0F1, 8'h20, 8'h33, 8'h44, 8'h00, 1'b1);
        wait_drain(20, "wrap_drain1");
        chk("wrap_seq_ffff", last_hs_d, 64'hFFFF_2044_3300_00F1);
        send_pulse(9'h0F2, 8'h40, 8'h55, 8'h66, 8'h00, 1'b1);
        wait_drain(20, "wrap_drain2");
        chk("wrap_seq_0000", last_hs_d, 64'h0000_4066_5500_00F2);

        // Reset while in SEND with five events buffered.
        do_reset();
        event_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_pulse(9'(i + 9'h80), 8'h03, 8'(i), 8'h70, 8'h00, 1'b1);
        end
        repeat (3) tick();
        chk("pre_rst_valid", 64'(event_valid), 64'd1);
        do_reset();
        chk("mid_rst_valid", 64'(event_valid), 64'd0);
        chk("mid_rst_data", event_data, 64'h0);
        chk("mid_rst_full", 64'(evtBuf_full), 64'd0);
        chk("mid_rst_cnt_event", 64'(cnt_event), 64'd0);
        chk("mid_rst_cnt_drop", 64'(cnt_drop), 64'd0);
        event_ready = 1'b1;
        seen_v = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_v += int'(event_valid);
        end
        chk("mid_rst_buf_empty", 64'(seen_v), 64'd0);
        send_pulse(9'h123, 8'h80, 8'h9A, 8'hBC, 8'h00, 1'b1);
        wait_drain(20, "post_rst_drain");
        chk("post_rst_event", last_hs_d, 64'h0000_80BC_9A00_0123);
        chk("post_rst_cnt_event", 64'(cnt_event), stat(1));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
